// File: rtl/fifo_port_ctrl_if.sv
// Handshake and FIFO-port bundle for fifo_port_ctrl.
// master = controller side, slave = producers/consumer/FIFO side.
interface fifo_port_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  p0_valid;
    logic [DATA_WIDTH-1:0] p0_data;
    logic                  p0_ready;
    logic                  p1_valid;
    logic [DATA_WIDTH-1:0] p1_data;
    logic                  p1_ready;
    logic                  c_valid;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  c_ready;
    logic                  fifo_write;
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic                  fifo_full;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;

    modport master (
        input  p0_valid, p0_data,
        output p0_ready,
        input  p1_valid, p1_data,
        output p1_ready,
        output c_valid, c_data,
        input  c_ready,
        output fifo_write, fifo_data_in,
        input  fifo_full,
        output fifo_read,
        input  fifo_data_out, fifo_empty
    );

    modport slave (
        output p0_valid, p0_data,
        input  p0_ready,
        output p1_valid, p1_data,
        input  p1_ready,
        input  c_valid, c_data,
        output c_ready,
        input  fifo_write, fifo_data_in,
        output fifo_full,
        input  fifo_read,
        output fifo_data_out, fifo_empty
    );
endinterface

// File: rtl/fifo_port_ctrl.sv
// Two-producer round-robin FIFO writer plus a 3-state read sequencer
// feeding one valid/ready consumer, with saturating accept counters.
module fifo_port_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_port_ctrl_if.master     bus,
    output logic                 last_grant,
    output logic [CNT_WIDTH-1:0] p0_cnt,
    output logic [CNT_WIDTH-1:0] p1_cnt
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CAP  = 2'd1,
        R_HOLD = 2'd2
    } rstate_t;

    rstate_t state, state_n;
    logic    allow;
    logic    gnt0;
    logic    gnt1;

    // On a tie the producer that did not win last time is served.
    always_comb begin
        allow = en & ~bus.fifo_full;
        gnt0  = allow & bus.p0_valid
              & (~bus.p1_valid | last_grant);
        gnt1  = allow & bus.p1_valid
              & (~bus.p0_valid | ~last_grant);
    end

    always_comb begin
        bus.p0_ready     = gnt0;
        bus.p1_ready     = gnt1;
        bus.fifo_write   = gnt0 | gnt1;
        bus.fifo_data_in = '0;
        unique case (1'b1)
            gnt0:    bus.fifo_data_in = bus.p0_data;
            gnt1:    bus.fifo_data_in = bus.p1_data;
            default: bus.fifo_data_in = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            p0_cnt     <= '0;
            p1_cnt     <= '0;
        end else begin
            if (gnt0) begin
                last_grant <= 1'b0;
                if (p0_cnt != '1)
                    p0_cnt <= p0_cnt + CNT_WIDTH'(1);
            end
            if (gnt1) begin
                last_grant <= 1'b1;
                if (p1_cnt != '1)
                    p1_cnt <= p1_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_n       = state;
        bus.fifo_read = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (en && !bus.fifo_empty) begin
                    bus.fifo_read = 1'b1;
                    state_n       = R_CAP;
                end
            end
            R_CAP:   state_n = R_HOLD;
            R_HOLD: begin
                if (bus.c_ready)
                    state_n = R_IDLE;
            end
            default: state_n = R_IDLE;
        endcase
    end

    // FIFO output is registered, so capture happens one cycle after the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= R_IDLE;
            bus.c_valid <= 1'b0;
            bus.c_data  <= '0;
        end else begin
            state <= state_n;
            if (state == R_CAP) begin
                bus.c_data  <= bus.fifo_data_out;
                bus.c_valid <= 1'b1;
            end else if (state == R_HOLD && bus.c_ready) begin
                bus.c_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_port_ctrl.sv
// Directed bench for fifo_port_ctrl: vector table for arbitration,
// hand sequences for the read FSM, saturation and async reset.
module tb_fifo_port_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       last_grant;
    logic [7:0] p0_cnt;
    logic [7:0] p1_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_port_ctrl_if #(.DATA_WIDTH(8)) bus ();

    fifo_port_ctrl #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .last_grant(last_grant),
        .p0_cnt    (p0_cnt),
        .p1_cnt    (p1_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       full;
        logic       p0v;
        logic [7:0] p0d;
        logic       p1v;
        logic [7:0] p1d;
        logic       r0;
        logic       r1;
        logic       wr;
        logic [7:0] din;
        logic       lg;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00,
                   1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 8'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22,
                   1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'd1, 8'd1};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 8'hB0,
                   1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'd2, 8'd1};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 8'hB0,
                   1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 8'd2, 8'd2};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1,
                   1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 8'd3, 8'd2};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 8'hB1,
                   1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 8'd3, 8'd3};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 8'hA2, 1'b1, 8'hB2,
                   1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd3, 8'd3};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2,
                   1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd3, 8'd3};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 8'hB2,
                   1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 8'd4, 8'd3};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00,
                   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd4, 8'd3};
        vt[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h33,
                   1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'd4, 8'd4};

        rst               = 1'b1;
        en                = 1'b0;
        bus.p0_valid      = 1'b0;
        bus.p0_data       = 8'h00;
        bus.p1_valid      = 1'b0;
        bus.p1_data       = 8'h00;
        bus.c_ready       = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = 8'h00;

        #12;
        chk("rst_c_valid", 32'(bus.c_valid), 32'h0);
        chk("rst_c_data", 32'(bus.c_data), 32'h0);
        chk("rst_fifo_read", 32'(bus.fifo_read), 32'h0);
        chk("rst_last_grant", 32'(last_grant), 32'h1);
        chk("rst_p0_cnt", 32'(p0_cnt), 32'h0);
        chk("rst_p1_cnt", 32'(p1_cnt), 32'h0);
        chk("rst_fifo_write", 32'(bus.fifo_write), 32'h0);
        chk("rst_fifo_din", 32'(bus.fifo_data_in), 32'h0);

        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            en            = vt[i].en;
            bus.fifo_full = vt[i].full;
            bus.p0_valid  = vt[i].p0v;
            bus.p0_data   = vt[i].p0d;
            bus.p1_valid  = vt[i].p1v;
            bus.p1_data   = vt[i].p1d;
            #1;
            chk($sformatf("v%0d_p0_ready", i),
                32'(bus.p0_ready), 32'(vt[i].r0));
            chk($sformatf("v%0d_p1_ready", i),
                32'(bus.p1_ready), 32'(vt[i].r1));
            chk($sformatf("v%0d_fifo_write", i),
                32'(bus.fifo_write), 32'(vt[i].wr));
            chk($sformatf("v%0d_fifo_din", i),
                32'(bus.fifo_data_in), 32'(vt[i].din));
            tick();
            chk($sformatf("v%0d_last_grant", i),
                32'(last_grant), 32'(vt[i].lg));
            chk($sformatf("v%0d_p0_cnt", i),
                32'(p0_cnt), 32'(vt[i].c0));
            chk($sformatf("v%0d_p1_cnt", i),
                32'(p1_cnt), 32'(vt[i].c1));
        end

        // Read with a same-cycle write from p0.
        bus.p1_valid   = 1'b0;
        en             = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.p0_valid   = 1'b1;
        bus.p0_data    = 8'h99;
        #1;
        chk("rd_pulse", 32'(bus.fifo_read), 32'h1);
        chk("rd_wr_same_cycle", 32'(bus.fifo_write), 32'h1);
        chk("rd_wr_din", 32'(bus.fifo_data_in), 32'h99);
        tick();
        bus.p0_valid      = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = 8'h5C;
        #1;
        chk("rd_cap_no_read", 32'(bus.fifo_read), 32'h0);
        chk("rd_cap_c_valid", 32'(bus.c_valid), 32'h0);
        chk("rd_p0_cnt", 32'(p0_cnt), 32'd5);
        tick();
        bus.fifo_data_out = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_hold%0d_valid", i),
                32'(bus.c_valid), 32'h1);
            chk($sformatf("rd_hold%0d_data", i),
                32'(bus.c_data), 32'h5C);
            chk($sformatf("rd_hold%0d_no_read", i),
                32'(bus.fifo_read), 32'h0);
            tick();
        end
        bus.c_ready = 1'b1;
        #1;
        chk("rd_take_valid", 32'(bus.c_valid), 32'h1);
        chk("rd_take_data", 32'(bus.c_data), 32'h5C);
        tick();
        bus.c_ready = 1'b0;
        chk("rd_done_valid", 32'(bus.c_valid), 32'h0);

        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("empty%0d_no_read", i),
                32'(bus.fifo_read), 32'h0);
            tick();
        end

        // en dropped while the read is in flight.
        bus.fifo_empty = 1'b0;
        #1;
        chk("en_rd_pulse", 32'(bus.fifo_read), 32'h1);
        tick();
        en                = 1'b0;
        bus.fifo_data_out = 8'h7E;
        tick();
        chk("en_hold_valid", 32'(bus.c_valid), 32'h1);
        chk("en_hold_data", 32'(bus.c_data), 32'h7E);
        bus.c_ready = 1'b1;
        tick();
        bus.c_ready = 1'b0;
        chk("en_done_valid", 32'(bus.c_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("en_off%0d_no_read", i),
                32'(bus.fifo_read), 32'h0);
            tick();
        end
        en = 1'b1;
        #1;
        chk("en_back_pulse", 32'(bus.fifo_read), 32'h1);
        tick();
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = 8'h42;
        tick();
        chk("sat_hold_valid", 32'(bus.c_valid), 32'h1);
        chk("sat_hold_data", 32'(bus.c_data), 32'h42);

        // Saturate p1 while the consumer stalls in R_HOLD.
        bus.p1_valid = 1'b1;
        bus.p1_data  = 8'h55;
        for (int i = 0; i < 250; i++) tick();
        chk("sat_p1_254", 32'(p1_cnt), 32'd254);
        tick();
        chk("sat_p1_255", 32'(p1_cnt), 32'd255);
        tick();
        tick();
        chk("sat_p1_hold", 32'(p1_cnt), 32'd255);
        chk("sat_p1_ready", 32'(bus.p1_ready), 32'h1);
        chk("sat_p0_cnt", 32'(p0_cnt), 32'd5);
        chk("sat_still_valid", 32'(bus.c_valid), 32'h1);

        bus.p1_valid = 1'b0;
        rst          = 1'b1;
        #1;
        chk("arst_c_valid", 32'(bus.c_valid), 32'h0);
        chk("arst_c_data", 32'(bus.c_data), 32'h0);
        chk("arst_p0_cnt", 32'(p0_cnt), 32'h0);
        chk("arst_p1_cnt", 32'(p1_cnt), 32'h0);
        chk("arst_last_grant", 32'(last_grant), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(bus.c_valid), 32'h0);
        chk("post_rst_no_read", 32'(bus.fifo_read), 32'h0);
        bus.p0_valid = 1'b1;
        bus.p1_valid = 1'b1;
        #1;
        chk("post_rst_tie_p0", 32'(bus.p0_ready), 32'h1);
        chk("post_rst_tie_p1", 32'(bus.p1_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
